dram_sequencer: RTL and testbench

DRAM_SEQUENCER -- requirements
Module: dram_sequencer

---
 rtl/ggf_pkg.sv | 19 +
 rtl/refresh_scheduler.sv | 52 +++++
 rtl/dram_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_dram_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ggf_pkg.sv
// Shared defaults and FSM state type for the DRAM sequencer.
package ggf_pkg;

  localparam int unsigned DEF_REFRESH_INTERVAL = 108;
  localparam int unsigned DEF_TRP              = 2;
  localparam int unsigned DEF_TCAS             = 2;
  localparam int unsigned DEF_MAX_PENDING      = 3;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    COL,
    CAS,
    PRE,
    REF_CAS,
    REF_RAS
  } seq_state_e;

endpackage

// File: rtl/refresh_scheduler.sv
// Refresh interval timer and pending-refresh backlog counter.
module refresh_scheduler
  import ggf_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
  parameter int unsigned MAX_PENDING      = DEF_MAX_PENDING
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       consume,
  output logic [1:0] pending,
  output logic       overrun
);

  localparam int unsigned TW = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [1:0]  MAXP = 2'(MAX_PENDING);

  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          tick;

  assign tick    = (timer_q == TW'(REFRESH_INTERVAL - 1));
  assign pending = pending_q;
  assign overrun = overrun_q;

  // Timer wrap, backlog update and sticky overrun.
  always_comb begin
    timer_d   = tick ? '0 : timer_q + 1'b1;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (tick && !consume) begin
      if (pending_q == MAXP) overrun_d = 1'b1;
      else                   pending_d = pending_q + 2'd1;
    end else if (consume && !tick && pending_q != '0) begin
      pending_d = pending_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: rtl/dram_sequencer.sv
// DRAM access / CAS-before-RAS refresh sequencer with registered strobes.
module dram_sequencer
  import ggf_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
  parameter int unsigned TRP              = DEF_TRP,
  parameter int unsigned TCAS             = DEF_TCAS,
  parameter int unsigned MAX_PENDING      = DEF_MAX_PENDING
) (
  input  logic CLK,
  input  logic RESET,
  input  logic REQ,
  input  logic WRITE,
  input  logic UDS,
  input  logic LDS,
  output logic ADDR_SEL,
  output logic RASn,
  output logic UCASn,
  output logic LCASn,
  output logic MEMWn,
  output logic ACK,
  output logic REF_OVERRUN
);

  localparam logic [1:0] MAXP = 2'(MAX_PENDING);

  seq_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wr_q, wr_d, uds_q, uds_d, lds_q, lds_d;
  logic       ras_n_q, ras_n_d, ucas_n_q, ucas_n_d, lcas_n_q, lcas_n_d;
  logic       memw_n_q, memw_n_d, addr_sel_q, addr_sel_d, ack_q, ack_d;
  logic [1:0] pending;
  logic       overrun;
  logic       consume;

  assign consume = (state_q == REF_CAS);

  refresh_scheduler #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL),
    .MAX_PENDING     (MAX_PENDING)
  ) u_sched (
    .clk    (CLK),
    .rst    (RESET),
    .consume(consume),
    .pending(pending),
    .overrun(overrun)
  );

  // Next state, phase counter and latched cycle attributes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    uds_d   = uds_q;
    lds_d   = lds_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pending == MAXP)    state_d = REF_CAS;
        else if (REQ)           state_d = ROW;
        else if (pending != '0) state_d = REF_CAS;
      end
      ROW: begin
        wr_d    = WRITE;
        uds_d   = UDS;
        lds_d   = LDS;
        state_d = COL;
      end
      COL: begin
        cnt_d   = '0;
        state_d = CAS;
      end
      CAS: begin
        // cnt saturates at TCAS so ACK fires once however long REQ is held
        if (cnt_q != 3'(TCAS)) cnt_d = cnt_q + 3'd1;
        if (!REQ && cnt_q >= 3'(TCAS - 1)) begin
          cnt_d   = '0;
          state_d = PRE;
        end
      end
      PRE: begin
        if (cnt_q == 3'(TRP - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      REF_CAS: begin
        cnt_d   = '0;
        state_d = REF_RAS;
      end
      REF_RAS: begin
        if (cnt_q == 3'd1) begin
          cnt_d   = '0;
          state_d = PRE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered.
  always_comb begin
    ras_n_d    = 1'b1;
    ucas_n_d   = 1'b1;
    lcas_n_d   = 1'b1;
    memw_n_d   = 1'b1;
    addr_sel_d = 1'b0;
    ack_d      = 1'b0;
    case (state_d)
      ROW: ras_n_d = 1'b0;
      COL: begin
        ras_n_d    = 1'b0;
        addr_sel_d = 1'b1;
        memw_n_d   = ~wr_d;
      end
      CAS: begin
        ras_n_d    = 1'b0;
        addr_sel_d = 1'b1;
        ucas_n_d   = ~uds_d;
        lcas_n_d   = ~lds_d;
        memw_n_d   = ~wr_d;
        ack_d      = (cnt_d == 3'(TCAS - 1));
      end
      REF_CAS: begin
        ucas_n_d = 1'b0;
        lcas_n_d = 1'b0;
      end
      REF_RAS: begin
        ras_n_d  = 1'b0;
        ucas_n_d = 1'b0;
        lcas_n_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      uds_q      <= 1'b0;
      lds_q      <= 1'b0;
      ras_n_q    <= 1'b1;
      ucas_n_q   <= 1'b1;
      lcas_n_q   <= 1'b1;
      memw_n_q   <= 1'b1;
      addr_sel_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      uds_q      <= uds_d;
      lds_q      <= lds_d;
      ras_n_q    <= ras_n_d;
      ucas_n_q   <= ucas_n_d;
      lcas_n_q   <= lcas_n_d;
      memw_n_q   <= memw_n_d;
      addr_sel_q <= addr_sel_d;
      ack_q      <= ack_d;
    end
  end

  assign RASn        = ras_n_q;
  assign UCASn       = ucas_n_q;
  assign LCASn       = lcas_n_q;
  assign MEMWn       = memw_n_q;
  assign ADDR_SEL    = addr_sel_q;
  assign ACK         = ack_q;
  assign REF_OVERRUN = overrun;

endmodule

// File: tb/tb_dram_sequencer.sv
// Self-checking bench: waveform-queue reference model plus pinned literal checkpoints.
module tb_dram_sequencer;

  localparam int RI   = 108;
  localparam int TRPV = 2;
  localparam int TCV  = 2;
  localparam int MAXP = 3;

  logic CLK = 1'b0;
  logic RESET, REQ, WRITE, UDS, LDS;
  logic ADDR_SEL, RASn, UCASn, LCASn, MEMWn, ACK, REF_OVERRUN;

  always #5 CLK = ~CLK;

  dram_sequencer #(
    .REFRESH_INTERVAL(RI),
    .TRP             (TRPV),
    .TCAS            (TCV),
    .MAX_PENDING     (MAXP)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .REQ        (REQ),
    .WRITE      (WRITE),
    .UDS        (UDS),
    .LDS        (LDS),
    .ADDR_SEL   (ADDR_SEL),
    .RASn       (RASn),
    .UCASn      (UCASn),
    .LCASn      (LCASn),
    .MEMWn      (MEMWn),
    .ACK        (ACK),
    .REF_OVERRUN(REF_OVERRUN)
  );

  // One expected output word per clock; idle/refcas tags drive scheduling decisions.
  typedef struct packed {
    logic ras_n, ucas_n, lcas_n, memw_n, addr, ack, idle, refcas;
  } word_t;

  function automatic word_t mk(logic r, logic u, logic l, logic m, logic a, logic k,
                               logic i, logic rc);
    word_t w;
    w = '{ras_n: r, ucas_n: u, lcas_n: l, memw_n: m, addr: a, ack: k, idle: i, refcas: rc};
    return w;
  endfunction

  // ---------------- reference model ----------------
  word_t q[$];
  word_t cur, nxt;
  bit    holding;
  int    timer, pending, cyc, epoch;
  bit    overrun_m, model_valid, prev_rst;
  bit    tick, consume;

  initial begin
    epoch = -1; cyc = 0; model_valid = 0; prev_rst = 0;
  end

  task automatic start_refresh();
    q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1));
    q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < TRPV; k++) q.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0));
  endtask

  task automatic start_access(logic w, logic u, logic l);
    q.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0));
    q.push_back(mk(0, 1, 1, ~w, 1, 0, 0, 0));
    for (int k = 0; k < TCV; k++) q.push_back(mk(0, ~u, ~l, ~w, 1, (k == TCV - 1), 0, 0));
    holding = 1;
  endtask

  logic lw, lu, ll;

  always @(posedge CLK) begin
    if (RESET) begin
      if (!prev_rst) epoch++;
      q.delete();
      holding = 0; cur = mk(1, 1, 1, 1, 0, 0, 1, 0);
      timer = 0; pending = 0; overrun_m = 0; cyc = 0;
    end else begin
      cyc++;
      tick    = (timer == RI - 1);
      timer   = tick ? 0 : timer + 1;
      consume = cur.refcas;
      if (q.size() > 0) nxt = q.pop_front();
      else if (holding) begin
        if (REQ) nxt = mk(0, ~lu, ~ll, ~lw, 1, 0, 0, 0);
        else begin
          holding = 0;
          for (int k = 0; k < TRPV; k++) q.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0));
          nxt = q.pop_front();
        end
      end
      else if (!cur.idle) nxt = mk(1, 1, 1, 1, 0, 0, 1, 0);
      else if (pending == MAXP) begin start_refresh(); nxt = q.pop_front(); end
      else if (REQ) begin
        lw = WRITE; lu = UDS; ll = LDS;
        start_access(lw, lu, ll); nxt = q.pop_front();
      end
      else if (pending > 0) begin start_refresh(); nxt = q.pop_front(); end
      else nxt = mk(1, 1, 1, 1, 0, 0, 1, 0);
      if (tick && !consume) begin
        if (pending == MAXP) overrun_m = 1; else pending++;
      end else if (consume && !tick && pending > 0) pending--;
      cur = nxt;
    end
    prev_rst    = RESET;
    model_valid = 1;
  end

  // ---------------- literal checkpoints ----------------
  int lit_ep [100];
  int lit_cyc[100];
  int lit_sig[100];
  logic lit_val[100];
  int nlits = 0;

  task automatic add_lit(int ep, int c, int s, logic v);
    lit_ep[nlits] = ep; lit_cyc[nlits] = c; lit_sig[nlits] = s; lit_val[nlits] = v;
    nlits++;
  endtask

  function automatic string sig_name(int s);
    case (s)
      0: return "RASn";
      1: return "UCASn";
      2: return "LCASn";
      3: return "MEMWn";
      4: return "ADDR_SEL";
      5: return "ACK";
      default: return "REF_OVERRUN";
    endcase
  endfunction

  // ---------------- compare process ----------------
  int  total = 0, bad = 0;
  bit  done = 0;
  bit  lit_hit[100];
  logic [6:0] act, expv;

  always @(negedge CLK) begin
    if (model_valid) begin
      act  = {RASn, UCASn, LCASn, MEMWn, ADDR_SEL, ACK, REF_OVERRUN};
      expv = {cur.ras_n, cur.ucas_n, cur.lcas_n, cur.memw_n, cur.addr, cur.ack, overrun_m};
      total++;
      if (act !== expv) begin
        bad++;
        $display("FAIL model_cmp ep=%0d cyc=%0d got(RAS,UCAS,LCAS,MEMW,ASEL,ACK,OVR)=%b want=%b",
                 epoch, cyc, act, expv);
      end
      for (int i = 0; i < nlits; i++) begin
        if (lit_ep[i] == epoch && lit_cyc[i] == cyc) begin
          lit_hit[i] = 1;
          total++;
          if (act[6 - lit_sig[i]] !== lit_val[i]) begin
            bad++;
            $display("FAIL lit_%s ep=%0d cyc=%0d got=%b want=%b", sig_name(lit_sig[i]),
                     epoch, cyc, act[6 - lit_sig[i]], lit_val[i]);
          end
        end
      end
    end
    if (done) begin
      for (int i = 0; i < nlits; i++) begin
        total++;
        if (!lit_hit[i]) begin
          bad++;
          $display("FAIL lit_reached ep=%0d cyc=%0d got=unvisited want=visited",
                   lit_ep[i], lit_cyc[i]);
        end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_to(int c);
    int g = 0;
    while (cyc != c && g < 5000) begin
      @(negedge CLK);
      g++;
    end
  endtask

  task automatic drive_req(logic w, logic u, logic l);
    WRITE = w; UDS = u; LDS = l; REQ = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  int hold;

  initial begin
    RESET = 1; REQ = 0; WRITE = 0; UDS = 0; LDS = 0;
    for (int s = 0; s < 7; s++) add_lit(0, 0, s, (s < 4) ? 1'b1 : 1'b0);
    // idle refresh: tick at 108, CBR at 109
    add_lit(0, 108, 1, 1);
    add_lit(0, 109, 1, 0); add_lit(0, 109, 2, 0); add_lit(0, 109, 0, 1);
    add_lit(0, 110, 0, 0); add_lit(0, 110, 1, 0); add_lit(0, 111, 0, 0);
    add_lit(0, 112, 0, 1); add_lit(0, 112, 1, 1); add_lit(0, 113, 0, 1);
    // upper-byte read
    add_lit(0, 121, 0, 0); add_lit(0, 121, 4, 0);
    add_lit(0, 122, 4, 1); add_lit(0, 122, 3, 1);
    add_lit(0, 123, 1, 0); add_lit(0, 123, 2, 1); add_lit(0, 123, 5, 0);
    add_lit(0, 124, 5, 1); add_lit(0, 124, 3, 1); add_lit(0, 125, 5, 0);
    add_lit(0, 126, 0, 0); add_lit(0, 127, 0, 1); add_lit(0, 128, 0, 1);
    // write colliding with a tick
    add_lit(0, 216, 0, 0); add_lit(0, 217, 3, 0); add_lit(0, 217, 4, 1);
    add_lit(0, 218, 3, 0); add_lit(0, 218, 1, 0); add_lit(0, 218, 2, 0);
    add_lit(0, 219, 5, 1); add_lit(0, 220, 3, 1); add_lit(0, 220, 0, 1);
    add_lit(0, 223, 1, 0); add_lit(0, 223, 0, 1); add_lit(0, 224, 0, 0);
    // long hold across four ticks
    add_lit(0, 647, 6, 0); add_lit(0, 648, 6, 1); add_lit(0, 660, 0, 1);
    add_lit(0, 663, 1, 0); add_lit(0, 663, 0, 1);
    add_lit(0, 669, 0, 0); add_lit(0, 669, 4, 0); add_lit(0, 670, 4, 1);
    add_lit(0, 671, 1, 1); add_lit(0, 671, 2, 0); add_lit(0, 672, 5, 1);
    // reset in REF_RAS, then in CAS, then a no-byte read
    add_lit(1, 109, 1, 0); add_lit(1, 110, 0, 0);
    add_lit(2, 0, 0, 1); add_lit(2, 0, 1, 1); add_lit(2, 0, 2, 1); add_lit(2, 0, 5, 0);
    add_lit(2, 7, 1, 0); add_lit(2, 7, 3, 0);
    add_lit(3, 0, 0, 1); add_lit(3, 0, 1, 1); add_lit(3, 0, 2, 1);
    add_lit(3, 0, 3, 1); add_lit(3, 0, 4, 0); add_lit(3, 0, 5, 0);
    add_lit(3, 3, 0, 0); add_lit(3, 5, 1, 1); add_lit(3, 5, 2, 1);
    add_lit(3, 5, 0, 0); add_lit(3, 5, 4, 1); add_lit(3, 6, 5, 1);
    add_lit(3, 7, 0, 1); add_lit(3, 7, 5, 0);

    repeat (3) @(negedge CLK);
    RESET = 0;

    wait_to(120); drive_req(0, 1, 0);
    wait_to(126); REQ = 0;
    wait_to(215); drive_req(1, 1, 1);
    wait_to(219); REQ = 0;
    wait_to(300); drive_req(0, 1, 1);
    wait_to(659); REQ = 0;
    wait_to(662); drive_req(0, 0, 1);
    wait_to(679); REQ = 0;

    wait_to(700); RESET = 1; @(negedge CLK); RESET = 0;
    wait_to(110); RESET = 1; @(negedge CLK); RESET = 0;
    wait_to(4);   drive_req(1, 1, 1);
    wait_to(7);   RESET = 1; REQ = 0; @(negedge CLK); RESET = 0;
    wait_to(2);   drive_req(0, 0, 0);
    wait_to(6);   REQ = 0;

    for (int it = 0; it < 150; it++) begin
      repeat ($urandom_range(1, 20)) @(negedge CLK);
      drive_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      hold = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 350))
                                          : int'($urandom_range(1, 10));
      for (int h = 0; h < hold; h++) begin
        @(negedge CLK);
        if (RESET) RESET = 0;
        else if ($urandom_range(0, 299) == 0) RESET = 1;
      end
      RESET = 0; REQ = 0;
    end
    repeat (20) @(negedge CLK);
    done = 1;
  end

endmodule
